// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with a first-word fall-through
// receive FIFO.
//
// Parameters
//   UART_CLK_DIV : half-bit period in clk cycles (baud = clk / (2*UART_CLK_DIV)), min 2
//   FIFO_ASIZE   : log2 of the receive FIFO depth in bytes
//
// Optional feature
//   UART_RX_PARITY_EN : when defined, one even-parity bit follows data bit 7
//                       and parity_err reports mismatches; otherwise 8N1.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   i_uart_rx  : serial line, idle high, asynchronous to clk
//   rvalid     : FIFO non-empty, rdata holds the head byte
//   rready     : consumer pops the head byte when rvalid & rready
//   rdata      : head-of-FIFO byte; holds the last popped byte while empty
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overflow   : one-cycle pulse, completed byte dropped because FIFO full
//   parity_err : one-cycle pulse on parity mismatch (constant 0 without parity)
//   dbg_state  : current receive FSM state encoding
//
// Handshake: a byte transfers on every rising edge where rvalid and rready
// are both high; rvalid never depends on rready, and rready may be held high.
module uart_rx #(
  parameter int UART_CLK_DIV = 868,
  parameter int FIFO_ASIZE   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic       rvalid,
  input  logic       rready,
  output logic [7:0] rdata,
  output logic       frame_err,
  output logic       overflow,
  output logic       parity_err,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(2 * UART_CLK_DIV);
  localparam logic [CW-1:0] HALF_BIT = CW'(UART_CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(2 * UART_CLK_DIV - 1);
  localparam int DEPTH = 1 << FIFO_ASIZE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t          state;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            byte_ready;

  assign dbg_state = state;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], i_uart_rx};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  // Receive FSM. The cycle counter is cleared at every sample point so it
  // never wraps inside a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF_BIT) begin
            cnt   <= '0;
            // A line already back high at mid start bit was a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_BIT) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            if (!rx_s) begin
              // Framing error wins over a parity mismatch.
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              if ((^shreg) != par_bit) parity_err <= 1'b1;
              else                     byte_ready <= 1'b1;
`else
              byte_ready <= 1'b1;
`endif
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold off while a break keeps the line low.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Receive FIFO, first-word fall-through.
  logic [7:0]          mem [DEPTH];
  logic [FIFO_ASIZE:0] wptr, rptr;
  logic [7:0]          last_data;
  logic                empty, full, pop, push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_ASIZE] != rptr[FIFO_ASIZE]) &&
                 (wptr[FIFO_ASIZE-1:0] == rptr[FIFO_ASIZE-1:0]);
  assign pop   = !empty && rready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push  = byte_ready && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_ASIZE-1:0]] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= byte_ready && !push;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr      <= rptr + 1'b1;
        last_data <= mem[rptr[FIFO_ASIZE-1:0]];
      end
    end
  end

  assign rvalid = !empty;
  assign rdata  = empty ? last_data : mem[rptr[FIFO_ASIZE-1:0]];

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter UART_CLK_DIV, default 868, meaning half-bit period in clk cycles (baud = clk/(2*UART_CLK_DIV)); legal minimum 2.
REQ-002 SHALL have parameter FIFO_ASIZE, default 10, meaning RX buffer depth = 2^FIFO_ASIZE bytes.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_uart_rx  input  1  serial line from host-PC UART-TXD, idle high, asynchronous to clk.
REQ-006 SHALL have port rvalid  output  1  FIFO non-empty; rdata valid.
REQ-007 SHALL have port rready  input  1  consumer pops head byte when rvalid&rready.
REQ-008 SHALL have port rdata  output  8  head-of-FIFO byte (first-word fall-through).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse, completed byte dropped because FIFO full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 SHALL pass i_uart_rx through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized signal.
REQ-013 SHALL implement FSM IDLE, START, DATA, PARITY (only when compiled in), STOP, WAIT_IDLE.
REQ-014 IDLE: synchronized line low -> START, bit counter cleared, cycle counter cleared.
REQ-015 START: after UART_CLK_DIV cycles (mid start bit) sample; low -> DATA; high -> IDLE (glitch rejected, nothing reported).
REQ-016 DATA: sample every 2*UART_CLK_DIV cycles, 8 bits, LSB first, shifted into the data register; after bit 7 -> PARITY or STOP.
REQ-017 STOP: sample after 2*UART_CLK_DIV cycles; high -> byte offered to FIFO, go IDLE; low -> frame_err pulse, byte discarded, go WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until synchronized line high, then IDLE (no false start on a break condition).
REQ-019 Cycle counter SHALL be wide enough for 2*UART_CLK_DIV-1 and SHALL not wrap mid-bit.
REQ-020 Write to FIFO SHALL occur in the cycle after the stop-bit sample; rvalid asserts the cycle after the write.
REQ-021 A completed byte SHALL be accepted if FIFO not full, or full with a pop in the same cycle; otherwise dropped with overflow pulse; stored contents unaffected.
REQ-022 Pop with FIFO empty SHALL be ignored; rdata holds last value when rvalid=0.
REQ-023 FIFO pointers SHALL be FIFO_ASIZE+1 bits, wrapping naturally; full = MSBs differ, lower bits equal.
REQ-024 Error pulses and the receive FSM SHALL be independent of rready.

Reset
REQ-025 On rst: FSM=IDLE, counters 0, synchronizer 1, FIFO empty, rvalid=0, rdata=0, frame_err=overflow=parity_err=0.
REQ-026 Reset mid-frame SHALL abandon the partial byte; after release, reception resumes at the next falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7, sampled 2*UART_CLK_DIV cycles later; mismatch -> parity_err pulse at the stop sample, byte discarded (frame_err takes priority if both).
REQ-028 Macro UART_RX_PARITY_EN undefined: 8N1 framing, PARITY state absent, parity_err constant 0.

Verification (UART_CLK_DIV=4, bit=8 cycles, FIFO_ASIZE=2)
REQ-029 Send 8N1 0x55 then 0xA3, rready=1 -> rdata 0x55 then 0xA3, each rvalid one cycle, no error pulses.
REQ-030 Drive line low 3 cycles then high -> no rvalid, no error; following frame 0x0F received correctly.
REQ-031 Send 0x7E with stop bit low for 16 cycles -> one frame_err pulse, no FIFO write, next frame 0x01 received.
REQ-032 rready=0, send 0x10..0x14 -> rvalid=1, exactly one overflow pulse (on 0x14); then popping yields 0x10,0x11,0x12,0x13.
REQ-033 Assert rst during DATA bit 4 of 0xFF -> all outputs at reset values, no byte stored; next frame 0x3C received.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> one parity_err pulse, nothing stored.
